// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM state encoding, PC width default and the decoder's reset-state instruction word.
package instruction_fetch_unit_pkg;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      FETCH  = 2'd1,
      ISSUE  = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

   localparam int          PC_WIDTH_DEFAULT          = 16;
   localparam int          INSTRUCTION_WIDTH_DEFAULT = 16;
   localparam logic [15:0] RESET_INSTRUCTION_WORD    = 16'hFFFF;

endpackage

// File: rtl/fetch_pc_register.sv
// Program counter: reset to RESET_VECTOR, redirect load beats sequential increment; wraps modulo 2^PC_WIDTH.
// Updates on the clock edge after load/increment; no backpressure of its own.
module fetch_pc_register
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                  PC_WIDTH     = PC_WIDTH_DEFAULT,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                load,
   input  logic [PC_WIDTH-1:0] load_value,
   input  logic                increment,
   output logic [PC_WIDTH-1:0] pc
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc <= RESET_VECTOR;
      end else if (load) begin
         pc <= load_value;
      end else if (increment) begin
         pc <= pc + PC_WIDTH'(1);
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one word per FETCH/ISSUE pair, instr_valid one cycle after mem_ready; stall holds ISSUE.
// Optional 32-bit accepted-fetch counter output fetch_count when INSTRUCTION_FETCH_COUNTER_EN is defined.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                           INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEFAULT,
   parameter int                           PC_WIDTH          = PC_WIDTH_DEFAULT,
   parameter logic [PC_WIDTH-1:0]          RESET_VECTOR      = '0,
   parameter logic [INSTRUCTION_WIDTH-1:0] RESET_INSTRUCTION = INSTRUCTION_WIDTH'(RESET_INSTRUCTION_WORD)
) (
   input  logic                         clock,
   input  logic                         reset,
   output logic                         mem_req,
   output logic [PC_WIDTH-1:0]          mem_addr,
   input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
   input  logic                         mem_ready,
   input  logic                         stall,
   input  logic                         redirect_valid,
   input  logic [PC_WIDTH-1:0]          redirect_target,
   input  logic                         halt,
   input  logic                         resume,
   output logic [INSTRUCTION_WIDTH-1:0] instruction,
   output logic                         instr_valid,
   output logic [PC_WIDTH-1:0]          instr_pc,
   output logic                         halted
`ifdef INSTRUCTION_FETCH_COUNTER_EN
   ,
   output logic [31:0]                  fetch_count
`endif
);

   fetch_state_t        state;
   fetch_state_t        state_nxt;
   logic [PC_WIDTH-1:0] pc;
   logic                pc_load;
   logic                pc_inc;
   logic                capture;
   logic                valid_nxt;
   logic                halted_nxt;

   fetch_pc_register #(
      .PC_WIDTH     (PC_WIDTH),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pc (
      .clock      (clock),
      .reset      (reset),
      .load       (pc_load),
      .load_value (redirect_target),
      .increment  (pc_inc),
      .pc         (pc)
   );

   // Request decodes straight from state so a reset drops it in the same cycle.
   assign mem_req  = (state == FETCH);
   assign mem_addr = pc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
      capture    = 1'b0;
      valid_nxt  = instr_valid;
      halted_nxt = halted;
      case (state)
         BOOT: begin
            state_nxt = FETCH;
            valid_nxt = 1'b1;
         end
         FETCH: begin
            if (redirect_valid) begin
               pc_load   = 1'b1;
               valid_nxt = 1'b0;
            end else if (mem_ready) begin
               capture   = 1'b1;
               pc_inc    = 1'b1;
               valid_nxt = 1'b1;
               state_nxt = ISSUE;
            end else begin
               valid_nxt = 1'b0;
            end
         end
         ISSUE: begin
            if (redirect_valid) begin
               pc_load   = 1'b1;
               valid_nxt = 1'b0;
               state_nxt = FETCH;
            end else if (halt) begin
               valid_nxt  = 1'b0;
               halted_nxt = 1'b1;
               state_nxt  = HALTED;
            end else if (!stall) begin
               valid_nxt = 1'b0;
               state_nxt = FETCH;
            end
         end
         HALTED: begin
            valid_nxt = 1'b0;
            pc_load   = redirect_valid;
            if (resume) begin
               halted_nxt = 1'b0;
               state_nxt  = FETCH;
            end
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         instruction <= RESET_INSTRUCTION;
         instr_pc    <= RESET_VECTOR;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         instr_valid <= valid_nxt;
         halted      <= halted_nxt;
         if (capture) begin
            instruction <= mem_rdata;
            instr_pc    <= pc;
         end
      end
   end

`ifdef INSTRUCTION_FETCH_COUNTER_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_count <= '0;
      end else if (capture) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed test-plan sequences, then randomized traffic against a cycle model.
module tb_instruction_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_target;
   logic        halt;
   logic        resume;
   logic [15:0] instruction;
   logic        instr_valid;
   logic [15:0] instr_pc;
   logic        halted;
`ifdef INSTRUCTION_FETCH_COUNTER_EN
   logic [31:0] fetch_count;
`endif

   always #5 clock = ~clock;

   instruction_fetch_unit dut (
      .clock           (clock),
      .reset           (reset),
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_rdata       (mem_rdata),
      .mem_ready       (mem_ready),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .halt            (halt),
      .resume          (resume),
      .instruction     (instruction),
      .instr_valid     (instr_valid),
      .instr_pc        (instr_pc),
      .halted          (halted)
`ifdef INSTRUCTION_FETCH_COUNTER_EN
      ,
      .fetch_count     (fetch_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Model: what the decoder side must see, tracked per phase of the fetch protocol.
   localparam int M_BOOT = 0, M_WAIT = 1, M_HOLD = 2, M_HALT = 3;
   int          m_mode;
   logic [15:0] m_pc, m_instr, m_ipc;
   logic        m_valid, m_halted;
   logic [31:0] m_cnt;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'h2A00;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_BOOT; m_pc = 16'h0000; m_instr = 16'hFFFF; m_ipc = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_cnt = 32'd0;
   endtask

   task automatic model_step();
      if (m_mode == M_BOOT) begin
         m_valid = 1'b1;
         m_mode  = M_WAIT;
      end else if (m_mode == M_WAIT) begin
         if (redirect_valid) begin
            m_pc = redirect_target; m_valid = 1'b0;
         end else if (mem_ready) begin
            m_instr = mem_word(m_pc); m_ipc = m_pc; m_pc = m_pc + 16'd1;
            m_valid = 1'b1; m_cnt = m_cnt + 32'd1; m_mode = M_HOLD;
         end else begin
            m_valid = 1'b0;
         end
      end else if (m_mode == M_HOLD) begin
         if (redirect_valid) begin
            m_pc = redirect_target; m_valid = 1'b0; m_mode = M_WAIT;
         end else if (halt) begin
            m_valid = 1'b0; m_halted = 1'b1; m_mode = M_HALT;
         end else if (!stall) begin
            m_valid = 1'b0; m_mode = M_WAIT;
         end
      end else begin
         if (redirect_valid) m_pc = redirect_target;
         if (resume) begin
            m_halted = 1'b0; m_mode = M_WAIT;
         end
      end
   endtask

   task automatic compare_all();
      chk("mem_req", 32'(mem_req), 32'(m_mode == M_WAIT));
      if (m_mode == M_WAIT) chk("mem_addr", 32'(mem_addr), 32'(m_pc));
      chk("instruction", 32'(instruction), 32'(m_instr));
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
      chk("halted", 32'(halted), 32'(m_halted));
`ifdef INSTRUCTION_FETCH_COUNTER_EN
      chk("fetch_count", fetch_count, m_cnt);
`endif
   endtask

   task automatic cyc();
      @(posedge clock);
      if (reset) model_reset();
      else model_step();
      @(negedge clock);
      compare_all();
      mem_rdata = mem_word(mem_addr);
   endtask

   initial begin
      reset = 1'b1; mem_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
      redirect_target = 16'h0000; halt = 1'b0; resume = 1'b0; mem_rdata = 16'h0000;
      model_reset();
      repeat (2) @(negedge clock);
      compare_all();
      chk("rst_instr", 32'(instruction), 32'h0000FFFF);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      mem_rdata = mem_word(mem_addr);

      reset = 1'b0; mem_ready = 1'b1;
      cyc();
      chk("boot_instr", 32'(instruction), 32'h0000FFFF);
      chk("boot_valid", 32'(instr_valid), 32'd1);
      chk("boot_addr", 32'(mem_addr), 32'h0);
      cyc();
      chk("first_instr", 32'(instruction), 32'h00002A00);
      chk("first_pc", 32'(instr_pc), 32'h0);
      cyc();
      chk("next_addr", 32'(mem_addr), 32'h1);

      for (int i = 0; i < 40 && !(mem_req === 1'b1 && mem_addr === 16'h0004); i++) cyc();
      chk("reach_pc4", 32'(mem_addr), 32'h4);
      mem_ready = 1'b0;
      repeat (3) begin
         cyc();
         chk("wait_req", 32'(mem_req), 32'd1);
         chk("wait_addr", 32'(mem_addr), 32'h4);
      end
      mem_ready = 1'b1;
      cyc();
      chk("late_valid", 32'(instr_valid), 32'd1);
      chk("late_instr", 32'(instruction), 32'h00002A04);
      cyc();
      cyc();
      chk("stall_instr", 32'(instruction), 32'h00002A05);
      stall = 1'b1;
      repeat (5) begin
         cyc();
         chk("stall_hold_instr", 32'(instruction), 32'h00002A05);
         chk("stall_hold_pc", 32'(instr_pc), 32'h5);
         chk("stall_hold_valid", 32'(instr_valid), 32'd1);
         chk("stall_no_req", 32'(mem_req), 32'd0);
      end
      stall = 1'b0;
      cyc();
      chk("post_stall_addr", 32'(mem_addr), 32'h6);

      redirect_valid = 1'b1; redirect_target = 16'h0010; mem_ready = 1'b0;
      cyc();
      chk("redir_addr10", 32'(mem_addr), 32'h10);
      mem_ready = 1'b1; redirect_target = 16'h0040;
      cyc();
      chk("redir_discard_addr", 32'(mem_addr), 32'h40);
      chk("redir_discard_valid", 32'(instr_valid), 32'd0);
      redirect_valid = 1'b0;
      cyc();
      chk("redir_ipc", 32'(instr_pc), 32'h40);
      chk("redir_instr", 32'(instruction), 32'h00002A40);

      halt = 1'b1;
      cyc();
      halt = 1'b0;
      chk("halt_flag", 32'(halted), 32'd1);
      repeat (10) begin
         cyc();
         chk("halt_hold", 32'(halted), 32'd1);
         chk("halt_no_req", 32'(mem_req), 32'd0);
      end
      resume = 1'b1;
      cyc();
      resume = 1'b0;
      chk("resume_addr", 32'(mem_addr), 32'h41);
      chk("resume_halted", 32'(halted), 32'd0);

      mem_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 16'hFFFF;
      cyc();
      redirect_valid = 1'b0; mem_ready = 1'b1;
      cyc();
      chk("wrap_ipc", 32'(instr_pc), 32'h0000FFFF);
      chk("wrap_instr", 32'(instruction), 32'h0000D5FF);
      cyc();
      chk("wrap_addr", 32'(mem_addr), 32'h0);
`ifdef INSTRUCTION_FETCH_COUNTER_EN
      chk("count_directed", fetch_count, 32'd8);
`endif

      reset = 1'b1;
      #1;
      model_reset();
      chk("midrst_req", 32'(mem_req), 32'd0);
      chk("midrst_instr", 32'(instruction), 32'h0000FFFF);
`ifdef INSTRUCTION_FETCH_COUNTER_EN
      chk("midrst_count", fetch_count, 32'd0);
`endif
      cyc();
      reset = 1'b0;

      for (int n = 0; n < 4000; n++) begin
         mem_ready       = ($urandom_range(0, 1) == 0);
         stall           = ($urandom_range(0, 9) < 4);
         redirect_valid  = ($urandom_range(0, 99) < 8);
         redirect_target = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
         halt            = ($urandom_range(0, 99) < 15);
         resume          = ($urandom_range(0, 9) < 3);
         reset           = ($urandom_range(0, 199) == 0);
         if (reset) begin
            #1;
            model_reset();
            compare_all();
         end
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Owns the PC and issues word-addressed reads to instruction memory through a req/ready handshake.
- Latches each returned 16-bit instruction into an instruction register that drives the decoder's Instruction input.
- Handles decoder stall, branch/SWI redirect, HLT and resume; presents 16'hFFFF (decoder reset-state encoding) after reset.

Parameters:
- INSTRUCTION_WIDTH, 16, instruction word width.
- PC_WIDTH, 16, PC and memory word-address width.
- RESET_VECTOR, 0, PC value loaded on reset.
- RESET_INSTRUCTION, 16'hFFFF, instruction register content during reset and boot.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  instruction read request.
- mem_addr  out  PC_WIDTH  word address; equals pc while mem_req=1.
- mem_rdata  in  INSTRUCTION_WIDTH  read data; valid when mem_ready=1.
- mem_ready  in  1  read completes this cycle; may respond combinationally in the cycle mem_req rises.
- stall  in  1  decode/execute not ready; hold the current instruction.
- redirect_valid  in  1  load a new PC (taken branch, BX, SWI).
- redirect_target  in  PC_WIDTH  new PC.
- halt  in  1  HLT decoded on the issued instruction.
- resume  in  1  leave HALTED.
- instruction  out  INSTRUCTION_WIDTH  instruction register, to the decoder.
- instr_valid  out  1  instruction holds a live fetched word (or the boot word).
- instr_pc  out  PC_WIDTH  address the instruction was fetched from.
- halted  out  1  high in HALTED.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is asynchronous and active-high; all state clears immediately on assertion.
  - Reset values: pc=RESET_VECTOR, instruction=RESET_INSTRUCTION, instr_pc=RESET_VECTOR, instr_valid=0, mem_req=0, halted=0, state=BOOT.
- States: BOOT, FETCH, ISSUE, HALTED. All outputs are registered except mem_req and mem_addr, which decode combinationally from state and pc.
- BOOT:
  - First cycle after reset release: instruction stays 16'hFFFF and instr_valid=1 for exactly one cycle.
  - Next state is FETCH regardless of stall.
- FETCH:
  - mem_req=1, mem_addr=pc; request and address are held stable until mem_ready.
  - On mem_ready at the clock edge: instruction<=mem_rdata, instr_pc<=pc, pc<=pc+1, instr_valid<=1, next state ISSUE.
  - Latency is one cycle from the ready cycle to instr_valid.
  - pc+1 wraps modulo 2^PC_WIDTH; 16'hFFFF+1 gives 0 with no flag.
- ISSUE:
  - instr_valid=1; the instruction is consumed in a cycle with stall=0.
  - stall=1: hold all outputs, no memory request.
  - stall=0 and halt=1: next state HALTED, instr_valid<=0.
  - stall=0 and halt=0: next state FETCH, instr_valid<=0.
  - Throughput: at most one instruction per 2 cycles (multicycle core).
- HALTED:
  - mem_req=0, instr_valid=0, halted=1.
  - resume=1: next state FETCH at the current pc.
- Redirect:
  - redirect_valid=1 in FETCH or ISSUE: pc<=redirect_target, instr_valid<=0, next state FETCH.
  - Any same-cycle mem_ready data is discarded.
  - Overrides stall and halt.
- Priority, highest first: reset > redirect > halt > resume > stall.
- Reset mid-fetch: the request drops immediately; a late mem_ready is ignored because mem_req=0.
- In BOOT, redirect_valid, halt and resume are ignored.
- In HALTED, redirect_valid loads pc but the state remains HALTED; redirect and resume in the same cycle resume at redirect_target.

Optional Feature:
- Macro: INSTRUCTION_FETCH_COUNTER_EN.
- Defined:
  - Adds output fetch_count (32 bits), reset to 0.
  - Increments once per accepted fetch (FETCH with mem_ready and no redirect); wraps at 2^32.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package:
  - fetch state encoding, 2 bits: BOOT=0, FETCH=1, ISSUE=2, HALTED=3.
  - RESET_INSTRUCTION constant 16'hFFFF, shared with the decoder's reset-state encoding.
  - PC_WIDTH default.
- Sub-module: one natural sub-module, fetch_pc_register, holding pc with load, increment, redirect and reset.
- FSM and instruction register stay in the top.

Test Plan:
- Reset release, mem_ready tied 1 -> cycle 1: instruction=16'hFFFF, instr_valid=1; then mem_addr=0x0000; after ready, instruction=mem[0], instr_pc=0, next fetch address 0x0001.
- mem_ready delayed 3 cycles at pc=0x0004 -> mem_req and mem_addr=0x0004 stable for 4 cycles; instr_valid rises the cycle after ready.
- stall=1 for 5 cycles in ISSUE with instruction=0x2A05 -> instruction, instr_pc and instr_valid unchanged and mem_req=0 throughout; fetch resumes the cycle after stall=0.
- redirect_valid with target 0x0040 in the same cycle as mem_ready at pc=0x0010 -> data discarded, next mem_addr=0x0040, instr_pc of the next issued instruction=0x0040.
- halt=1 in ISSUE -> halted=1 and mem_req=0 for 10 cycles; resume=1 -> fetch at the next sequential pc.
- pc=0xFFFF fetched -> next mem_addr=0x0000.
- With INSTRUCTION_FETCH_COUNTER_EN defined, 7 fetches including one redirected fetch -> fetch_count=6.
- Reset asserted mid-FETCH -> mem_req drops the same cycle, instruction=16'hFFFF.
